// File: rtl/fpu_seq_cntrl.sv
// Sequenced RV64FD OP-FP decoder: accepts one instruction per handshake, decodes it,
// holds the result for a per-class latency, then presents it on a valid/ready done port.
module fpu_seq_cntrl #(
    parameter int INSTR_LEN  = 32,
    parameter int FPU_OP_LEN = 6,
    parameter int LAT_ADDSUB = 2,
    parameter int LAT_MUL    = 3,
    parameter int LAT_DIV    = 12,
    parameter int LAT_SQRT   = 16,
    parameter int LAT_MISC   = 1,
    parameter int ENABLE_D   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INSTR_LEN-1:0]  instruction,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            frm,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FPU_OP_LEN-1:0] fpu_op,
    output logic                  fpu_rs1,
    output logic                  fpu_rd,
    output logic [2:0]            rm_out,
    output logic                  illegal,
    output logic                  busy
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_LAT = max2(max2(max2(LAT_ADDSUB, LAT_MUL), max2(LAT_DIV, LAT_SQRT)), LAT_MISC);
    localparam int CW      = $clog2(MAX_LAT) + 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;

    logic [4:0] f5;
    logic [1:0] fmt;
    logic [2:0] rm, rm_res;
    logic [6:0] opc;
    logic       s, match, arith, bad_rm, ill;
    logic [5:0] d_op;
    logic       d_rd, d_rs1;
    logic [2:0] d_rm;
    logic [CW-1:0] d_lat;
    logic       unused_bits;

    assign f5  = instruction[31:27];
    assign fmt = instruction[26:25];
    assign rm  = instruction[14:12];
    assign opc = instruction[6:0];
    assign s   = (fmt == 2'b00);
    assign unused_bits = ^{instruction[24:15], instruction[11:7]};

    always_comb begin
        d_op  = 6'b0;
        match = 1'b0;
        arith = 1'b0;
        d_rd  = 1'b1;
        d_rs1 = 1'b1;
        d_lat = CW'(LAT_MISC);
        if (opc == 7'b1010011 && (fmt == 2'b00 || fmt == 2'b01)) begin
            case (f5)
                5'b00000: begin match = 1'b1; arith = 1'b1; d_op = {5'b00000, s}; d_lat = CW'(LAT_ADDSUB); end
                5'b00001: begin match = 1'b1; arith = 1'b1; d_op = {5'b00001, s}; d_lat = CW'(LAT_ADDSUB); end
                5'b00010: begin match = 1'b1; arith = 1'b1; d_op = {5'b00010, s}; d_lat = CW'(LAT_MUL); end
                5'b00011: begin match = 1'b1; arith = 1'b1; d_op = {5'b00011, s}; d_lat = CW'(LAT_DIV); end
                5'b01011: begin match = 1'b1; arith = 1'b1; d_op = {5'b00100, s}; d_lat = CW'(LAT_SQRT); end
                5'b00101: begin
                    match = (rm == 3'b000) || (rm == 3'b001);
                    d_op  = {4'b0100, rm[0], s};
                end
                5'b10100: begin
                    d_rd = 1'b0;
                    case (rm)
                        3'b010:  begin match = 1'b1; d_op = {5'b01010, s}; end
                        3'b001:  begin match = 1'b1; d_op = {5'b01011, s}; end
                        3'b000:  begin match = 1'b1; d_op = {5'b01100, s}; end
                        default: match = 1'b0;
                    endcase
                end
                5'b00100: begin
                    case (rm)
                        3'b000:  begin match = 1'b1; d_op = {5'b01101, s}; end
                        3'b001:  begin match = 1'b1; d_op = {5'b01110, s}; end
                        3'b010:  begin match = 1'b1; d_op = {5'b01111, s}; end
                        default: match = 1'b0;
                    endcase
                end
                5'b11100: begin
                    match = (fmt == 2'b01) && (rm == 3'b000);
                    d_op  = 6'b100000;
                    d_rd  = 1'b0;
                end
                5'b11110: begin
                    match = (fmt == 2'b01) && (rm == 3'b000);
                    d_op  = 6'b100001;
                    d_rs1 = 1'b0;
                end
                default: match = 1'b0;
            endcase
        end
        // rm=111 defers to the CSR; reserved codes in either source are illegal
        rm_res = (rm == 3'b111) ? frm : rm;
        bad_rm = arith && (rm_res == 3'b101 || rm_res == 3'b110 || rm_res == 3'b111);
        ill    = !match || (fmt == 2'b01 && ENABLE_D == 0) || bad_rm;
        d_rm   = arith ? rm_res : 3'b000;
        if (ill) begin
            d_op  = 6'b111111;
            d_rd  = 1'b0;
            d_rs1 = 1'b0;
            d_rm  = 3'b000;
            d_lat = CW'(1);
        end
    end

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    // cnt holds remaining EXEC cycles; DONE is entered as it would hit zero so
    // out_valid rises exactly LAT cycles after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            fpu_op    <= '0;
            fpu_rd    <= 1'b0;
            fpu_rs1   <= 1'b0;
            rm_out    <= 3'b000;
            illegal   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    fpu_op  <= FPU_OP_LEN'(d_op);
                    fpu_rd  <= d_rd;
                    fpu_rs1 <= d_rs1;
                    rm_out  <= d_rm;
                    illegal <= ill;
                    cnt     <= d_lat - CW'(1);
                    if (d_lat == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: if (flush) begin
                    state <= IDLE;
                end else begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (flush || out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_seq_cntrl.sv
// Scoreboard bench for fpu_seq_cntrl: stimulus pushes expected results, a negedge
// monitor pops and compares whenever out_valid is presented.
module tb_fpu_seq_cntrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = '0;
    logic        in_valid = 1'b0, in_valid2 = 1'b0;
    logic        in_ready, in_ready2;
    logic [2:0]  frm = 3'b000;
    logic        flush = 1'b0;
    logic        out_valid, out_valid2;
    logic        out_ready = 1'b1;
    logic [5:0]  fpu_op, fpu_op2;
    logic        fpu_rs1, fpu_rs12, fpu_rd, fpu_rd2;
    logic [2:0]  rm_out, rm_out2;
    logic        illegal, illegal2, busy, busy2;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [5:0] op;
        logic       rd;
        logic       rs1;
        logic [2:0] rm;
        logic       ill;
        int         cyc;
    } exp_t;
    exp_t q[$];
    bit seen = 1'b0;

    fpu_seq_cntrl dut (
        .clk(clk), .rst(rst), .instruction(instruction), .in_valid(in_valid),
        .in_ready(in_ready), .frm(frm), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .fpu_op(fpu_op), .fpu_rs1(fpu_rs1), .fpu_rd(fpu_rd),
        .rm_out(rm_out), .illegal(illegal), .busy(busy)
    );

    fpu_seq_cntrl #(.ENABLE_D(0)) dut_s (
        .clk(clk), .rst(rst), .instruction(instruction), .in_valid(in_valid2),
        .in_ready(in_ready2), .frm(frm), .flush(flush), .out_valid(out_valid2),
        .out_ready(1'b1), .fpu_op(fpu_op2), .fpu_rs1(fpu_rs12), .fpu_rd(fpu_rd2),
        .rm_out(rm_out2), .illegal(illegal2), .busy(busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] enc(input logic [4:0] f5, input logic [1:0] fmt,
                                        input logic [2:0] rm, input logic [6:0] opc);
        return {f5, fmt, 5'd2, 5'd1, rm, 5'd3, opc};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives an instruction and waits for acceptance; lat==0 means no result is expected.
    task automatic issue(input logic [31:0] ins, input logic [2:0] f, input logic [5:0] op,
                         input logic rd, input logic rs1, input logic [2:0] rmo,
                         input logic ill, input int lat, output int t);
        int n;
        exp_t e;
        instruction = ins;
        frm = f;
        in_valid = 1'b1;
        n = 0;
        #1;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout at cycle %0d: in_ready stayed 0", cyc);
        end
        t = cyc;
        if (lat > 0) begin
            e.op = op; e.rd = rd; e.rs1 = rs1; e.rm = rmo; e.ill = ill; e.cyc = t + lat;
            q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(in_ready && !out_valid) && n < 200) begin
            step();
            n++;
        end
        check("idle_timeout", {31'b0, in_ready}, 32'd1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out_valid at cycle %0d: op=%b", cyc, fpu_op);
            end else begin
                e = q[0];
                if (!seen) begin
                    check("out_valid_cycle", cyc, e.cyc);
                    seen = 1'b1;
                end
                check("result_fields", {20'b0, fpu_op, fpu_rd, fpu_rs1, rm_out, illegal},
                      {20'b0, e.op, e.rd, e.rs1, e.rm, e.ill});
                if (out_ready) begin
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_outputs", {20'b0, fpu_op, fpu_rd, fpu_rs1, rm_out, illegal, busy, out_valid}, 32'd0);

        // fadd.d: LAT 2, one-cycle out_valid, in_ready low while busy
        issue(enc(5'b00000, 2'b01, 3'b000, 7'b1010011), 3'b000, 6'b000000, 1, 1, 3'b000, 0, 2, t);
        step(); in_valid = 1'b0;
        check("fadd_in_ready_c1", {31'b0, in_ready}, 32'd0);
        check("fadd_busy_c1", {31'b0, busy}, 32'd1);
        step();
        check("fadd_in_ready_c2", {31'b0, in_ready}, 32'd0);
        step();
        check("fadd_in_ready_c3", {31'b0, in_ready}, 32'd1);
        check("fadd_out_valid_c3", {31'b0, out_valid}, 32'd0);

        // fdiv.s with dynamic rm: frm sampled at acceptance only
        issue(enc(5'b00011, 2'b00, 3'b111, 7'b1010011), 3'b011, 6'b000111, 1, 1, 3'b011, 0, 12, t);
        step(); in_valid = 1'b0; frm = 3'b000;
        wait_idle();

        // feq.d held by out_ready=0 for 5 cycles, in_valid kept high with fsub.s behind it
        out_ready = 1'b0;
        issue(enc(5'b10100, 2'b01, 3'b010, 7'b1010011), 3'b000, 6'b010100, 0, 1, 3'b000, 0, 1, t);
        step();
        instruction = enc(5'b00001, 2'b00, 3'b001, 7'b1010011);
        for (int i = 0; i < 5; i++) begin
            check("feq_hold_in_ready", {31'b0, in_ready}, 32'd0);
            check("feq_hold_out_valid", {31'b0, out_valid}, 32'd1);
            step();
        end
        out_ready = 1'b1;
        issue(enc(5'b00001, 2'b00, 3'b001, 7'b1010011), 3'b000, 6'b000011, 1, 1, 3'b001, 0, 2, t);
        check("fsub_accept_cycle_gap", {31'b0, in_ready}, 32'd1);
        step(); in_valid = 1'b0;
        wait_idle();

        // illegal encodings complete in one cycle
        issue(enc(5'b00000, 2'b00, 3'b000, 7'b0110011), 3'b000, 6'b111111, 0, 0, 3'b000, 1, 1, t);
        step(); in_valid = 1'b0; wait_idle();
        issue(enc(5'b00000, 2'b00, 3'b101, 7'b1010011), 3'b000, 6'b111111, 0, 0, 3'b000, 1, 1, t);
        step(); in_valid = 1'b0; wait_idle();
        issue(enc(5'b00010, 2'b01, 3'b111, 7'b1010011), 3'b110, 6'b111111, 0, 0, 3'b000, 1, 1, t);
        step(); in_valid = 1'b0; wait_idle();

        // fadd.d on the single-precision-only instance
        instruction = enc(5'b00000, 2'b01, 3'b000, 7'b1010011);
        in_valid2 = 1'b1;
        #1;
        check("sonly_in_ready", {31'b0, in_ready2}, 32'd1);
        step(); in_valid2 = 1'b0;
        check("sonly_fadd_d_illegal", {24'b0, out_valid2, illegal2, fpu_op2}, {24'b0, 2'b11, 6'b111111});
        step();

        // more legal ops: fmax.s, fmul.s, fmv.d.x, fmv.x.d
        issue(enc(5'b00101, 2'b00, 3'b001, 7'b1010011), 3'b000, 6'b010011, 1, 1, 3'b000, 0, 1, t);
        step(); in_valid = 1'b0; wait_idle();
        issue(enc(5'b00010, 2'b00, 3'b010, 7'b1010011), 3'b100, 6'b000101, 1, 1, 3'b010, 0, 3, t);
        step(); in_valid = 1'b0; wait_idle();
        issue(enc(5'b11110, 2'b01, 3'b000, 7'b1010011), 3'b000, 6'b100001, 1, 0, 3'b000, 0, 1, t);
        step(); in_valid = 1'b0; wait_idle();
        issue(enc(5'b11100, 2'b01, 3'b000, 7'b1010011), 3'b000, 6'b100000, 0, 1, 3'b000, 0, 1, t);
        step(); in_valid = 1'b0; wait_idle();

        // flush in IDLE does not block acceptance (fsgnjx.d)
        flush = 1'b1;
        issue(enc(5'b00100, 2'b01, 3'b010, 7'b1010011), 3'b000, 6'b011110, 1, 1, 3'b000, 0, 1, t);
        step(); in_valid = 1'b0; flush = 1'b0;
        wait_idle();

        // fsqrt.d killed by flush at cycle 5
        issue(enc(5'b01011, 2'b01, 3'b000, 7'b1010011), 3'b000, 6'b001000, 1, 1, 3'b000, 0, 0, t);
        step(); in_valid = 1'b0;
        repeat (4) step();
        flush = 1'b1;
        step(); flush = 1'b0;
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        check("flush_busy_valid", {30'b0, busy, out_valid}, 32'd0);
        check("flush_op_held", {26'b0, fpu_op}, 32'd8);
        repeat (15) step();

        // fsqrt.d killed by rst at cycle 5
        issue(enc(5'b01011, 2'b01, 3'b000, 7'b1010011), 3'b000, 6'b001000, 1, 1, 3'b000, 0, 0, t);
        step(); in_valid = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        #1;
        check("rst_in_ready_low", {31'b0, in_ready}, 32'd0);
        step();
        check("rst_outputs_zero", {20'b0, fpu_op, fpu_rd, fpu_rs1, rm_out, illegal, busy, out_valid}, 32'd0);
        rst = 1'b0;
        repeat (3) step();

        check("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
